// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: tx FSM states, frame length
// and the keyboard command bytes sent by the host.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_e;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] PS2_CMD_LED    = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin with a
// registered falling-edge strobe on the synced level.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fe
);

    logic s1;
    logic s2;
    logic prev;

    // Idle bus is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
            fe   <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            prev <= s2;
            fe   <= prev & ~s2;
        end
    end

    assign level = s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter using the
// request-to-send sequence, open-drain via pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_INHIBIT = INHIBIT;
    localparam logic [2:0] S_REQ     = REQ;
    localparam logic [2:0] S_SEND    = SEND;
    localparam logic [2:0] S_ACK     = ACK;
    localparam logic [2:0] S_WAIT    = WAIT_IDLE;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INH_LAST =
        IW'(INHIBIT_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST =
        WW'(TIMEOUT_CYCLES - 1);
    // Start bit goes out in REQ; the rest take one fe each.
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 2);

    logic [2:0]    state;
    logic [9:0]    shreg;
    logic [3:0]    cnt;
    logic [IW-1:0] inh;
    logic [WW-1:0] wd;

    logic clk_s;
    logic clk_fe;
    logic data_s;
    logic data_fe_unused;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_i),
        .level (clk_s),
        .fe    (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data_i),
        .level (data_s),
        .fe    (data_fe_unused)
    );

    assign tx_ready = (state == S_IDLE);
    assign tx_busy  = ~tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            inh         <= '0;
            wd          <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg <= {1'b1, ~^tx_data, tx_data};
                        cnt        <= '0;
                        inh        <= '0;
                        wd         <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_REQ;
                    end else begin
                        inh <= inh + 1'b1;
                    end
                end
                default: begin
                    wd <= wd + 1'b1;
                    // Timeout wins over any same-cycle edge.
                    if (wd == WD_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        case (state)
                            S_REQ: begin
                                ps2_clk_oe <= 1'b0;
                                state      <= S_SEND;
                            end
                            S_SEND: begin
                                if (clk_fe) begin
                                    ps2_data_oe <= ~shreg[0];
                                    shreg <= {1'b0, shreg[9:1]};
                                    cnt   <= cnt + 1'b1;
                                    if (cnt == LAST_BIT)
                                        state <= S_ACK;
                                end
                            end
                            S_ACK: begin
                                if (clk_fe) begin
                                    if (data_s) begin
                                        tx_error <= 1'b1;
                                        state    <= S_IDLE;
                                    end else begin
                                        state <= S_WAIT;
                                    end
                                end
                            end
                            S_WAIT: begin
                                if (clk_s && data_s) begin
                                    tx_done <= 1'b1;
                                    state   <= S_IDLE;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device
// model on a wired-AND bus (device clock scaled down).
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 2000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    int req_cyc = 0;
    int run = 0;
    int last_run = 0;
    logic req_prev = 1'b0;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        req_prev <= ps2_clk_oe && ps2_data_oe;
        if (ps2_clk_oe && ps2_data_oe && !req_prev)
            req_cyc <= cyc;
        if (ps2_clk_oe) begin
            run <= run + 1;
        end else begin
            if (run != 0) last_run <= run;
            run <= 0;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_clk_oe", ps2_clk_oe, 1);
    endtask

    task automatic dev_rx(input int nclk, input logic ack,
                          output logic [9:0] bits);
        int n;
        n = 0;
        bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_i == 1'b0)
               && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("bfm_start_seen", n < 5000, 1);
        repeat (H) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == 10 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) bits[i] = ps2_data_i;
            repeat (H) @(negedge clk);
            dev_data = 1'b1;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d,
                         input logic par,
                         input string tag);
        logic [9:0] b;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        dev_rx(11, 1'b1, b);
        repeat (10) @(negedge clk);
        chk({tag, "_data"}, b[7:0], d);
        chk({tag, "_parity"}, b[8], par);
        chk({tag, "_stop"}, b[9], 1);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err_cnt - e0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [9:0] b;
        int d0;
        int e0;
        int n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);

        // 0xED: bits 1,0,1,1,0,1,1,1 parity 1
        frame(8'hED, 1'b1, "ed");
        chk("inhibit_plus_req_len", last_run, INH + 1);
        frame(8'h07, 1'b0, "x07");
        frame(8'h00, 1'b1, "x00");

        // Device leaves data high on clock 11
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
        dev_rx(11, 1'b0, b);
        repeat (5) @(negedge clk);
        chk("noack_err", err_cnt - e0, 1);
        chk("noack_done", done_cnt - d0, 0);
        chk("noack_clk_oe", ps2_clk_oe, 0);
        chk("noack_data_oe", ps2_data_oe, 0);
        chk("noack_ready", tx_ready, 1);

        // Device never clocks
        e0 = err_cnt;
        send(8'h81);
        n = 0;
        while (err_cnt == e0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("to_seen", n < 3000, 1);
        repeat (2) @(negedge clk);
        chk("to_cycles", err_cyc - req_cyc, TO);
        chk("to_count", err_cnt - e0, 1);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);

        // Reset after fe 5; bit4 of 0x05 is 0 so data is pulled
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h05);
        dev_rx(5, 1'b0, b);
        chk("mid_data_oe", ps2_data_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_data_oe", ps2_data_oe, 0);
        chk("mid_rst_clk_oe", ps2_clk_oe, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_pulses",
            (done_cnt - d0) + (err_cnt - e0), 0);
        chk("mid_rst_ready", tx_ready, 1);
        frame(8'hF4, 1'b0, "f4");

        // Held valid: data change while busy is ignored
        d0 = done_cnt;
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("hold_accept", ps2_clk_oe, 1);
        tx_data = 8'hAA;
        dev_rx(11, 1'b1, b);
        chk("hold_first_data", b[7:0], 8'hFF);
        chk("hold_first_parity", b[8], 1);
        chk("hold_first_done", done_cnt - d0, 1);
        chk("hold_second_busy", tx_busy, 1);
        tx_valid = 1'b0;
        dev_rx(11, 1'b1, b);
        repeat (10) @(negedge clk);
        chk("hold_second_data", b[7:0], 8'hAA);
        chk("hold_second_parity", b[8], 1);
        chk("hold_second_done", done_cnt - d0, 2);
        chk("hold_idle", tx_ready, 1);

        chk("done_error_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
